// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern register, optional complement matching and overlap control.
// Optional saturating match counter is built only when SEQ_DETECT_MATCH_CNT_EN is defined.
module seq_detect_param #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter bit               MODE    = 1'b0,
    parameter bit               OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inp,
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             outp,
    output logic [15:0]      match_cnt
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FULL = FW'(WIDTH);

    typedef enum logic {FILL, ARMED} state_t;

    logic [WIDTH-1:0] hist, hist_nxt, hist_sh, pat_reg, pat_nxt;
    logic [FW-1:0]    fill_cnt, fill_nxt, fill_inc;
    logic             hit;
    state_t           state;

    // fill_cnt is the state register; the enum is just a decoded view of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            fill_cnt <= '0;
            pat_reg  <= PATTERN;
            outp     <= 1'b0;
        end else begin
            hist     <= hist_nxt;
            fill_cnt <= fill_nxt;
            pat_reg  <= pat_nxt;
            outp     <= hit;
        end
    end

    always_comb begin
        state    = (fill_cnt == FULL) ? ARMED : FILL;
        hist_sh  = {hist[WIDTH-2:0], inp};
        fill_inc = (state == ARMED) ? fill_cnt : fill_cnt + FW'(1);
        hist_nxt = hist;
        fill_nxt = fill_cnt;
        pat_nxt  = pat_reg;
        hit      = 1'b0;
        if (pat_load) begin
            // load wins over en: the incoming bit is dropped
            pat_nxt  = pat_in;
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (en) begin
            hit = (fill_inc == FULL) &&
                  ((hist_sh == pat_reg) || (MODE && (hist_sh == ~pat_reg)));
            if (hit && !OVERLAP) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = hist_sh;
                fill_nxt = fill_inc;
            end
        end
    end

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr_cnt)
            cnt <= '0;
        else if (hit && (cnt != 16'hFFFF))
            cnt <= cnt + 16'd1;
    end

    assign match_cnt = cnt;
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign match_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: four configurations driven by directed vectors,
// expected outp/match_cnt queued per cycle and checked by an independent monitor.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int          k;
        logic        eo;
        logic [15:0] ec;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en [4];
    logic        inp [4];
    logic        ld [4];
    logic        clr [4];
    logic [3:0]  pin [4];
    logic        o [4];
    logic [15:0] cnt [4];

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .MODE(1'b0), .OVERLAP(1'b1)) u_a (
        .clk(clk), .rst(rst), .en(en[0]), .inp(inp[0]), .pat_load(ld[0]), .pat_in(pin[0]),
        .clr_cnt(clr[0]), .outp(o[0]), .match_cnt(cnt[0]));

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .MODE(1'b0), .OVERLAP(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en[1]), .inp(inp[1]), .pat_load(ld[1]), .pat_in(pin[1]),
        .clr_cnt(clr[1]), .outp(o[1]), .match_cnt(cnt[1]));

    seq_detect_param #(.WIDTH(2), .PATTERN(2'b11), .MODE(1'b1), .OVERLAP(1'b0)) u_c (
        .clk(clk), .rst(rst), .en(en[2]), .inp(inp[2]), .pat_load(ld[2]), .pat_in(pin[2][1:0]),
        .clr_cnt(clr[2]), .outp(o[2]), .match_cnt(cnt[2]));

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1111), .MODE(1'b0), .OVERLAP(1'b1)) u_d (
        .clk(clk), .rst(rst), .en(en[3]), .inp(inp[3]), .pat_load(ld[3]), .pat_in(pin[3]),
        .clr_cnt(clr[3]), .outp(o[3]), .match_cnt(cnt[3]));

    function automatic logic [15:0] ce(input logic [15:0] x);
        return CNT_EN ? x : 16'h0000;
    endfunction

    // one cycle of stimulus on DUT k (others idle); optionally queue the expected response
    task automatic step(input int k, input logic e, input logic i, input logic l,
                        input logic [3:0] p, input logic c, input logic eo,
                        input logic [15:0] ec, input string nm, input bit chk);
        exp_t x;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            en[j] = 1'b0; inp[j] = 1'b0; ld[j] = 1'b0; clr[j] = 1'b0; pin[j] = 4'h0;
        end
        en[k] = e; inp[k] = i; ld[k] = l; pin[k] = p; clr[k] = c;
        if (chk) begin
            x.k = k; x.eo = eo; x.ec = ce(ec); x.nm = nm;
            q.push_back(x);
        end
    endtask

    task automatic acc(input int k, input logic i, input logic eo, input logic [15:0] ec,
                       input string nm);
        step(k, 1'b1, i, 1'b0, 4'h0, 1'b0, eo, ec, nm, 1'b1);
    endtask

    task automatic idle(input int k, input logic [15:0] ec, input string nm);
        step(k, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ec, nm, 1'b1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            nvec++;
            if (o[e.k] !== e.eo || cnt[e.k] !== e.ec) begin
                nerr++;
                $display("FAIL %s: dut%0d outp=%0b match_cnt=%h, expected outp=%0b match_cnt=%h",
                         e.nm, e.k, o[e.k], cnt[e.k], e.eo, e.ec);
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            en[j] = 1'b0; inp[j] = 1'b0; ld[j] = 1'b0; clr[j] = 1'b0; pin[j] = 4'h0;
        end
        idle(0, 0, "reset_a");
        idle(2, 0, "reset_c");
        @(negedge clk) rst = 1'b0;

        // overlap: 1,0,1,1,0,1,1
        acc(0, 1, 0, 0, "ovl_b1"); acc(0, 0, 0, 0, "ovl_b2"); acc(0, 1, 0, 0, "ovl_b3");
        acc(0, 1, 1, 1, "ovl_m1"); acc(0, 0, 0, 1, "ovl_b5"); acc(0, 1, 0, 1, "ovl_b6");
        acc(0, 1, 1, 2, "ovl_m2"); idle(0, 2, "ovl_idle");

        // non-overlap: same stream, only one match
        acc(1, 1, 0, 0, "novl_b1"); acc(1, 0, 0, 0, "novl_b2"); acc(1, 1, 0, 0, "novl_b3");
        acc(1, 1, 1, 1, "novl_m1"); acc(1, 0, 0, 1, "novl_b5"); acc(1, 1, 0, 1, "novl_b6");
        acc(1, 1, 0, 1, "novl_b7");

        // complement mode, width 2: 0,0,1,1,0,1
        acc(2, 0, 0, 0, "cmp_b1"); acc(2, 0, 1, 1, "cmp_m1"); acc(2, 1, 0, 1, "cmp_b3");
        acc(2, 1, 1, 2, "cmp_m2"); acc(2, 0, 0, 2, "cmp_b5"); acc(2, 1, 0, 2, "cmp_b6");

        // load 1011 to clear history, then 1,0,1,1 with enable gaps
        step(0, 1, 1, 1, 4'b1011, 0, 0, 2, "ld_1011", 1'b1);
        acc(0, 1, 0, 2, "gap_b1"); idle(0, 2, "gap_i1");
        acc(0, 0, 0, 2, "gap_b2"); idle(0, 2, "gap_i2");
        acc(0, 1, 0, 2, "gap_b3"); idle(0, 2, "gap_i3");
        acc(0, 1, 1, 3, "gap_m");  idle(0, 3, "gap_i4");

        // 3 bits, reset, then the 4th bit must not complete a match
        acc(0, 1, 0, 3, "pre_b1"); acc(0, 0, 0, 3, "pre_b2"); acc(0, 1, 0, 3, "pre_b3");
        @(negedge clk) rst = 1'b1;
        idle(0, 0, "rst_mid");
        @(negedge clk) rst = 1'b0;
        acc(0, 1, 0, 0, "rst_nopulse"); acc(0, 0, 0, 0, "rst_b2"); acc(0, 1, 0, 0, "rst_b3");
        acc(0, 1, 1, 1, "rst_m");

        // load 0110 mid-stream (inp discarded), then 0,1,1,0
        step(0, 1, 1, 1, 4'b0110, 0, 0, 1, "ld_0110", 1'b1);
        acc(0, 0, 0, 1, "ld_b1"); acc(0, 1, 0, 1, "ld_b2"); acc(0, 1, 0, 1, "ld_b3");
        acc(0, 0, 1, 2, "ld_m");
        // overlapping 0110 completes on the clr edge: clear wins
        acc(0, 1, 0, 2, "clr_b1"); acc(0, 1, 0, 2, "clr_b2");
        step(0, 1, 0, 0, 4'h0, 1, 1, 0, "clr_m", 1'b1);
        idle(0, 0, "clr_idle");

`ifdef SEQ_DETECT_MATCH_CNT_EN
        // all-ones pattern matches every bit once armed: 3 fill + 65534 matches -> FFFE
        for (int n = 0; n < 3 + 65534; n++)
            step(3, 1, 1, 0, 4'h0, 0, 0, 0, "", 1'b0);
        acc(3, 1, 1, 16'hFFFF, "sat_1");
        acc(3, 1, 1, 16'hFFFF, "sat_2");
        acc(3, 1, 1, 16'hFFFF, "sat_3");
        step(3, 1, 1, 0, 4'h0, 1, 1, 0, "sat_clr", 1'b1);
`endif

        repeat (4) @(posedge clk);
        #2;
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter WIDTH, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: reset value of the pattern register, WIDTH bits, MSB is the oldest bit.
REQ-003 Parameter MODE, default 0: 0 = match PATTERN only; 1 = match PATTERN or its bitwise complement.
REQ-004 Parameter OVERLAP, default 1: 1 = overlapping matches allowed; 0 = detector history cleared after each match.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port en, input, 1: inp is sampled at a rising clk edge only when en=1.
REQ-008 Port inp, input, 1: serial data bit.
REQ-009 Port pat_load, input, 1: when high at a rising clk edge, loads pat_in into the pattern register.
REQ-010 Port pat_in, input, WIDTH: new pattern value.
REQ-011 Port clr_cnt, input, 1: synchronous clear of match_cnt.
REQ-012 Port outp, output, 1: registered match pulse.
REQ-013 Port match_cnt, output, 16: saturating match count.

Function
REQ-014 The history shift register SHALL shift in inp at the LSB on each rising edge with en=1 and pat_load=0; it holds otherwise.
REQ-015 fill_cnt (0..WIDTH) SHALL increment on each accepted bit, saturate at WIDTH, and act as the FSM state: states FILL (fill_cnt<WIDTH) and ARMED (fill_cnt=WIDTH).
REQ-016 A match SHALL occur on an accepted bit when fill_cnt after the increment equals WIDTH and the post-shift history equals the pattern register (MODE=0), or equals the pattern register or its complement (MODE=1).
REQ-017 outp SHALL be set at the same edge that samples the completing bit, stay high for exactly one clk cycle, and be 0 in every other cycle, including all cycles with en=0.
REQ-018 With OVERLAP=1, fill_cnt SHALL remain at WIDTH after a match, so the next matching bit can match in the next accepted cycle.
REQ-019 With OVERLAP=0, a match SHALL clear history and fill_cnt to 0 at the same edge, so the next match needs WIDTH new accepted bits.
REQ-020 pat_load=1 SHALL load the pattern register, clear history and fill_cnt, drive outp to 0, and discard inp in that cycle, even when en=1.
REQ-021 Pattern comparison SHALL use the pattern register value current before the edge.
REQ-022 Bits beyond WIDTH-1 of internal registers SHALL NOT exist; pat_in is exactly WIDTH wide.

Reset
REQ-023 While rst=1: history=0, fill_cnt=0, pattern register=PATTERN, outp=0, match_cnt=0, independent of clk.
REQ-024 rst asserted mid-sequence SHALL discard partial history; the first possible match after release needs WIDTH new accepted bits.

Configuration
REQ-025 Macro SEQ_DETECT_MATCH_CNT_EN: when defined, match_cnt SHALL increment by 1 on each match and saturate at 16'hFFFF.
REQ-026 With SEQ_DETECT_MATCH_CNT_EN defined, clr_cnt=1 SHALL clear match_cnt to 0 and SHALL take priority over a same-edge match.
REQ-027 Without SEQ_DETECT_MATCH_CNT_EN, match_cnt SHALL be tied to 16'h0000, clr_cnt SHALL be ignored, and no counter flops SHALL be built.

Verification
REQ-028 Overlap test: WIDTH=4, PATTERN=1011, OVERLAP=1, en=1, inp=1,0,1,1,0,1,1 -> outp high after the 4th and 7th bits, match_cnt=2.
REQ-029 Non-overlap test: the same stream with OVERLAP=0 -> outp high only after the 4th bit, match_cnt=1.
REQ-030 Complement test: MODE=1, WIDTH=2, PATTERN=11, OVERLAP=0, inp=0,0,1,1,0,1 -> outp high after the 2nd and 4th bits only.
REQ-031 Enable gaps and load: for 1,0,1,1 with en=0 between bits -> exactly one outp pulse after the 4th accepted bit; pat_load with pat_in=0110 mid-stream then inp=0,1,1,0 -> one pulse after the 4th bit following the load.
REQ-032 Reset and saturation test: rst asserted after 3 of 4 pattern bits, then 1 more bit -> no pulse. With the counter preloaded to 16'hFFFE, 3 matches -> match_cnt=16'hFFFF. clr_cnt on the same edge as a match -> match_cnt=0.
